sipo_capture: RTL and testbench

SIPO_CAPTURE -- requirements
Module: sipo_capture

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_shift_core.sv | 46 ++++
 rtl/sipo_capture.sv | 82 ++++++++
 tb/tb_sipo_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in / parallel-out capture block.
package sipo_pkg;

    // Default number of serial bits per captured word.
    localparam int unsigned WIDTH_DEF = 8;

    // Holding-register state encodings.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Width of the partial-word bit counter; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter. Flags the completing bit with a one-cycle
// word_done pulse and presents the completed word alongside it.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_en,
    input  logic                       sync_clr,
    output logic [WIDTH-1:0]           word,
    output logic                       word_done,
    output logic [cnt_w(WIDTH)-1:0]    bit_cnt
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 bits need storing: the oldest bit falls out on every shift,
    // and the full word is formed with the incoming bit on the completing edge.
    logic [WIDTH-2:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == LAST);
    assign word      = {r_shift, din};
    assign word_done = din_en & ~sync_clr & w_last;
    assign bit_cnt   = r_cnt;

    // Shift in accepted bits MSB-first; counter wraps to 0 on the completing bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (sync_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (din_en) begin
            r_shift <= word[WIDTH-2:0];
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_capture.sv
// Serial-in / parallel-out capture with a single holding register, ready/valid
// output handshake and a sticky overrun flag for dropped words.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_en,
    input  logic                       sync_clr,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       out_valid,
    output logic                       overrun,
    output logic [cnt_w(WIDTH)-1:0]    bit_cnt
);

    logic [WIDTH-1:0] w_word;
    logic             w_done;

    logic             r_state;
    logic [WIDTH-1:0] r_dout;
    logic             r_overrun;

    logic             w_state_d;
    logic [WIDTH-1:0] w_dout_d;
    logic             w_overrun_d;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .sync_clr  (sync_clr),
        .word      (w_word),
        .word_done (w_done),
        .bit_cnt   (bit_cnt)
    );

    // Holding register next state: load when empty or being drained, else drop
    // the new word and flag overrun. sync_clr never coincides with w_done.
    always_comb begin
        w_state_d   = r_state;
        w_dout_d    = r_dout;
        w_overrun_d = r_overrun;
        if (sync_clr) begin
            w_overrun_d = 1'b0;
        end
        if (w_done) begin
            if ((r_state == ST_EMPTY) || out_ready) begin
                w_dout_d  = w_word;
                w_state_d = ST_FULL;
            end else begin
                w_overrun_d = 1'b1;
            end
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_d = ST_EMPTY;
        end
    end

    // Register holding state, word and overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_EMPTY;
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_dout    <= w_dout_d;
            r_overrun <= w_overrun_d;
        end
    end

    assign dout      = r_dout;
    assign out_valid = (r_state == ST_FULL);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_capture.sv
// Self-checking bench for sipo_capture (WIDTH=8): directed scenarios followed
// by random traffic, all compared against a word-level reference model.
module tb_sipo_capture;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_en;
    logic       sync_clr;
    logic       out_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       overrun;
    logic [2:0] bit_cnt;

    int n_total;
    int n_pass;

    // Reference model state
    int         m_cnt;
    int         m_acc;
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ovr;

    sipo_capture #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .sync_clr  (sync_clr),
        .out_ready (out_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, {24'd0, dout}, {24'd0, m_dout});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
        chk({tag, ".bit_cnt"}, {29'd0, bit_cnt}, m_cnt);
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_acc   = 0;
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Word-level behaviour of one clock edge.
    task automatic model_edge(input logic d, input logic en, input logic clr, input logic rdy);
        bit         done;
        logic [7:0] word;
        done = 1'b0;
        word = 8'h00;
        if (clr) begin
            m_cnt = 0;
            m_acc = 0;
            m_ovr = 1'b0;
        end else if (en) begin
            m_acc = (m_acc * 2 + int'(d)) % 256;
            m_cnt = m_cnt + 1;
            if (m_cnt == 8) begin
                done  = 1'b1;
                word  = 8'(m_acc);
                m_cnt = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_dout  = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic d, input logic en, input logic clr, input logic rdy,
                        input string tag);
        din       = d;
        din_en    = en;
        sync_clr  = clr;
        out_ready = rdy;
        @(posedge clk);
        model_edge(d, en, clr, rdy);
        #1;
        check_all(tag);
    endtask

    // Send a byte MSB-first; rdy applies to all bits but the last, which uses rdy_last.
    task automatic send_byte(input logic [7:0] b, input bit gap, input logic rdy,
                             input logic rdy_last, input string tag);
        for (int i = 7; i >= 0; i--) begin
            step(b[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, tag);
            if (gap && i != 0) step(1'b0, 1'b0, 1'b0, rdy, {tag, ".gap"});
        end
    endtask

    initial begin
        logic [7:0] v_a5;
        n_total   = 0;
        n_pass    = 0;
        v_a5      = 8'hA5;
        rst       = 1'b0;
        din       = 1'b0;
        din_en    = 1'b0;
        sync_clr  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        #10;
        rst = 1'b1;

        // Reset mid-word, then a clean 0xA5.
        for (int i = 7; i >= 5; i--) step(v_a5[i], 1'b1, 1'b0, 1'b0, "pre_rst");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0, "after_rst");
        chk("after_rst.a5", {24'd0, dout}, 32'hA5);
        chk("after_rst.valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "drain0");

        // Basic capture with consumer always ready: valid for exactly one cycle.
        send_byte(8'hA5, 1'b0, 1'b1, 1'b1, "basic");
        chk("basic.a5", {24'd0, dout}, 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, "basic.drop_valid");
        chk("basic.one_cycle", {31'd0, out_valid}, 32'd0);

        // Gapped enable.
        send_byte(8'hA5, 1'b1, 1'b1, 1'b1, "gapped");
        chk("gapped.a5", {24'd0, dout}, 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, "gapped.drain");

        // Back-to-back with stall: second word dropped, overrun set.
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0, "b2b.3c");
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0, "b2b.c3");
        chk("b2b.keep3c", {24'd0, dout}, 32'h3C);
        chk("b2b.overrun", {31'd0, overrun}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "b2b.consume");
        chk("b2b.empty", {31'd0, out_valid}, 32'd0);

        // Clear overrun, then completion coinciding with consume.
        step(1'b0, 1'b0, 1'b1, 1'b0, "clr0");
        send_byte(8'h11, 1'b0, 1'b0, 1'b0, "sim.11");
        send_byte(8'h22, 1'b0, 1'b0, 1'b1, "sim.22");
        chk("sim.dout22", {24'd0, dout}, 32'h22);
        chk("sim.valid", {31'd0, out_valid}, 32'd1);
        chk("sim.no_ovr", {31'd0, overrun}, 32'd0);

        // Force an overrun, then sync_clr after 5 bits, then 0xF0.
        send_byte(8'h55, 1'b0, 1'b0, 1'b0, "ovr.55");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "partial");
        step(1'b1, 1'b1, 1'b1, 1'b1, "sync_clr");
        chk("sync_clr.ovr", {31'd0, overrun}, 32'd0);
        chk("sync_clr.cnt", {29'd0, bit_cnt}, 32'd0);
        send_byte(8'hF0, 1'b0, 1'b0, 1'b0, "f0");
        chk("f0.dout", {24'd0, dout}, 32'hF0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(1)), ($urandom_range(3) != 0),
                 ($urandom_range(39) == 0), 1'($urandom_range(1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
